// File: rtl/memShare_config_pkg.sv
// Shared FSM state type and default geometry for the memShare request address generator.
package memShare_config_pkg;

    localparam int unsigned DRC_NUM_DEF     = 4;
    localparam int unsigned RD_ADDR_W_DEF   = 4;
    localparam int unsigned BUFF_ADDR_W_DEF = 6;
    localparam int unsigned BUFF_DEPTH_DEF  = 64;
    localparam int unsigned TRACK_DEPTH_DEF = 2;
    localparam int unsigned SHARE_LEN_DEF   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } memshare_state_e;

endpackage

// File: rtl/pipeReg_insert.sv
// Fixed-latency register pipeline of DEPTH stages; cleared by synchronous active-low reset.
module pipeReg_insert #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             sys_clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/memshare_multi_rqst_addr_gen.sv
// Generates message-buffer read addresses for one SCU.memShare() period with DRC-selected stride.
// Define MEMSHARE_RQST_STALL_EN to let rqst_ready_i backpressure the request stream.
module memshare_multi_rqst_addr_gen
    import memShare_config_pkg::*;
#(
    parameter int unsigned DRC_NUM     = DRC_NUM_DEF,
    parameter int unsigned RD_ADDR_W   = RD_ADDR_W_DEF,
    parameter int unsigned BUFF_ADDR_W = BUFF_ADDR_W_DEF,
    parameter int unsigned BUFF_DEPTH  = BUFF_DEPTH_DEF,
    parameter int unsigned TRACK_DEPTH = TRACK_DEPTH_DEF,
    parameter int unsigned SHARE_LEN   = SHARE_LEN_DEF
) (
    input  logic                         sys_clk,
    input  logic                         rstn,
    input  logic                         scu_begin_i,
    input  logic [BUFF_ADDR_W-1:0]       base_addr_i,
    input  logic [DRC_NUM*RD_ADDR_W-1:0] operand_i,
    input  logic [DRC_NUM-1:0]           is_drc_i,
    input  logic                         rqst_ready_i,
    output logic                         rqst_valid_o,
    output logic [BUFF_ADDR_W-1:0]       rqst_addr_o,
    output logic [RD_ADDR_W-1:0]         increment_operand_o,
    output logic [BUFF_ADDR_W-1:0]       drc_base_addr_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int unsigned OP_W  = DRC_NUM * RD_ADDR_W;
    localparam int unsigned CNT_W = $clog2(SHARE_LEN + 1);
    localparam int unsigned SUM_W = BUFF_ADDR_W + 1;

    memshare_state_e       state;
    logic [CNT_W-1:0]      rqst_cnt;
    logic                  drc_captured;
    logic [OP_W-1:0]       operand_dly;
    logic [RD_ADDR_W-1:0]  incr_sel;
    logic                  incr_found;
    logic [SUM_W-1:0]      addr_sum;
    logic [BUFF_ADDR_W-1:0] addr_next;
    logic                  rqst_ready;
    logic                  accept;

    pipeReg_insert #(
        .WIDTH (OP_W),
        .DEPTH (TRACK_DEPTH)
    ) u_operand_dly (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .d       (operand_i),
        .q       (operand_dly)
    );

`ifdef MEMSHARE_RQST_STALL_EN
    assign rqst_ready = rqst_ready_i;
`else
    // Ready is tied off: one request retires every RUN cycle.
    assign rqst_ready = rqst_ready_i | 1'b1;
`endif

    assign accept = rqst_valid_o & rqst_ready;

    // Lowest-index DRC hit picks the stride; unit stride when nothing hits.
    always_comb begin
        incr_sel   = RD_ADDR_W'(1);
        incr_found = 1'b0;
        for (int unsigned k = 0; k < DRC_NUM; k++) begin
            if (is_drc_i[k] && !incr_found) begin
                incr_sel   = operand_dly[k*RD_ADDR_W +: RD_ADDR_W];
                incr_found = 1'b1;
            end
        end
    end

    always_comb begin
        addr_sum  = SUM_W'(rqst_addr_o) + SUM_W'(increment_operand_o);
        addr_next = (addr_sum >= SUM_W'(BUFF_DEPTH))
                  ? BUFF_ADDR_W'(addr_sum - SUM_W'(BUFF_DEPTH))
                  : BUFF_ADDR_W'(addr_sum);
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            state               <= ST_IDLE;
            rqst_cnt            <= '0;
            drc_captured        <= 1'b0;
            rqst_valid_o        <= 1'b0;
            rqst_addr_o         <= '0;
            increment_operand_o <= RD_ADDR_W'(1);
            drc_base_addr_o     <= '0;
            busy_o              <= 1'b0;
            done_o              <= 1'b0;
        end else begin
            increment_operand_o <= incr_sel;
            if (scu_begin_i) begin
                // A restart overrides any completion in the same cycle.
                state        <= ST_RUN;
                rqst_addr_o  <= base_addr_i;
                rqst_cnt     <= '0;
                drc_captured <= 1'b0;
                rqst_valid_o <= 1'b1;
                busy_o       <= 1'b1;
                done_o       <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        rqst_valid_o <= 1'b0;
                        busy_o       <= 1'b0;
                        done_o       <= 1'b0;
                    end
                    ST_RUN: begin
                        if (!drc_captured && (|is_drc_i)) begin
                            drc_base_addr_o <= rqst_addr_o;
                            drc_captured    <= 1'b1;
                        end
                        if (accept) begin
                            rqst_addr_o <= addr_next;
                            rqst_cnt    <= rqst_cnt + CNT_W'(1);
                            if (rqst_cnt == CNT_W'(SHARE_LEN - 1)) begin
                                state        <= ST_DONE;
                                rqst_valid_o <= 1'b0;
                                busy_o       <= 1'b0;
                                done_o       <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        state        <= ST_IDLE;
                        rqst_valid_o <= 1'b0;
                        busy_o       <= 1'b0;
                        done_o       <= 1'b0;
                    end
                    default: begin
                        state        <= ST_IDLE;
                        rqst_valid_o <= 1'b0;
                        busy_o       <= 1'b0;
                        done_o       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_memshare_multi_rqst_addr_gen.sv
// Directed self-checking bench for memshare_multi_rqst_addr_gen (default parameters).
module tb_memshare_multi_rqst_addr_gen;

`ifdef MEMSHARE_RQST_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic        sys_clk;
    logic        rstn;
    logic        scu_begin_i;
    logic [5:0]  base_addr_i;
    logic [15:0] operand_i;
    logic [3:0]  is_drc_i;
    logic        rqst_ready_i;
    logic        rqst_valid_o;
    logic [5:0]  rqst_addr_o;
    logic [3:0]  increment_operand_o;
    logic [5:0]  drc_base_addr_o;
    logic        busy_o;
    logic        done_o;

    int n_vec;
    int n_err;
    int exp_addr;
    int n_left;

    memshare_multi_rqst_addr_gen dut (
        .sys_clk             (sys_clk),
        .rstn                (rstn),
        .scu_begin_i         (scu_begin_i),
        .base_addr_i         (base_addr_i),
        .operand_i           (operand_i),
        .is_drc_i            (is_drc_i),
        .rqst_ready_i        (rqst_ready_i),
        .rqst_valid_o        (rqst_valid_o),
        .rqst_addr_o         (rqst_addr_o),
        .increment_operand_o (increment_operand_o),
        .drc_base_addr_o     (drc_base_addr_o),
        .busy_o              (busy_o),
        .done_o              (done_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".valid"}, 32'(rqst_valid_o), 0);
        chk({tag, ".addr"},  32'(rqst_addr_o), 0);
        chk({tag, ".incr"},  32'(increment_operand_o), 1);
        chk({tag, ".drc"},   32'(drc_base_addr_o), 0);
        chk({tag, ".busy"},  32'(busy_o), 0);
        chk({tag, ".done"},  32'(done_o), 0);
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rstn         = 1'b0;
        scu_begin_i  = 1'b0;
        base_addr_i  = '0;
        operand_i    = '0;
        is_drc_i     = '0;
        rqst_ready_i = 1'b1;
        repeat (3) tick();
        chk_reset_vals("reset");
        rstn = 1'b1;
        tick();

        // Unit stride from base 5, sixteen requests then a single done pulse.
        base_addr_i = 6'd5;
        scu_begin_i = 1'b1;
        tick();
        scu_begin_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("s1.addr",  32'(rqst_addr_o), 32'(5 + i));
            chk("s1.valid", 32'(rqst_valid_o), 1);
            chk("s1.busy",  32'(busy_o), 1);
            chk("s1.done",  32'(done_o), 0);
            tick();
        end
        chk("s1.done_pulse", 32'(done_o), 1);
        chk("s1.valid_end",  32'(rqst_valid_o), 0);
        tick();
        chk("s1.done_clear", 32'(done_o), 0);
        chk("s1.idle_busy",  32'(busy_o), 0);

        // Stride 3 on channel 1 with wrap at 64; restart on the final acceptance.
        operand_i = 16'h0030;
        is_drc_i  = 4'b0010;
        repeat (3) tick();
        chk("s2.incr_pre", 32'(increment_operand_o), 3);
        base_addr_i = 6'd62;
        scu_begin_i = 1'b1;
        tick();
        scu_begin_i = 1'b0;
        exp_addr    = 62;
        for (int i = 0; i < 15; i++) begin
            chk("s2.addr", 32'(rqst_addr_o), 32'(exp_addr));
            if (i == 1) chk("s2.drc_base", 32'(drc_base_addr_o), 62);
            exp_addr = (exp_addr + 3) % 64;
            tick();
        end
        chk("s2.addr_last", 32'(rqst_addr_o), 32'(exp_addr));
        base_addr_i = 6'd10;
        scu_begin_i = 1'b1;
        tick();
        scu_begin_i = 1'b0;
        chk("s5.restart_addr",  32'(rqst_addr_o), 10);
        chk("s5.restart_done",  32'(done_o), 0);
        chk("s5.restart_valid", 32'(rqst_valid_o), 1);
        chk("s5.drc_hold",      32'(drc_base_addr_o), 62);
        tick();
        chk("s5.no_done",       32'(done_o), 0);
        chk("s5.drc_recapture", 32'(drc_base_addr_o), 10);
        chk("s5.addr_step",     32'(rqst_addr_o), 13);

        // Two DRC hits: channel 1 wins, new operand appears after TRACK_DEPTH+1 cycles.
        operand_i = 16'h0520;
        is_drc_i  = 4'b0110;
        tick();
        tick();
        chk("s3.incr_old", 32'(increment_operand_o), 3);
        tick();
        chk("s3.incr_new", 32'(increment_operand_o), 2);
        chk("s3.addr",     32'(rqst_addr_o), 22);

        // Zero stride holds the address.
        operand_i = 16'h0000;
        is_drc_i  = 4'b0001;
        tick();
        chk("s4.addr_a", 32'(rqst_addr_o), 24);
        tick();
        chk("s4.incr0",  32'(increment_operand_o), 0);
        chk("s4.addr_b", 32'(rqst_addr_o), 24);
        tick();
        chk("s4.addr_c", 32'(rqst_addr_o), 24);

        // Reset mid-RUN aborts the period without a done pulse.
        rstn      = 1'b0;
        operand_i = 16'h000f;
        tick();
        chk_reset_vals("midrst");
        rstn     = 1'b1;
        operand_i = '0;
        is_drc_i  = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst.no_done",  32'(done_o), 0);
            chk("midrst.no_valid", 32'(rqst_valid_o), 0);
        end

        // Ready low for three cycles mid-period.
        base_addr_i = 6'd0;
        scu_begin_i = 1'b1;
        tick();
        scu_begin_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("s6.addr_pre", 32'(rqst_addr_o), 32'(i));
            tick();
        end
        chk("s6.addr_4", 32'(rqst_addr_o), 4);
        rqst_ready_i = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("s6.stall_addr",  32'(rqst_addr_o), STALL_EN ? 32'd4 : 32'(5 + j));
            chk("s6.stall_valid", 32'(rqst_valid_o), 1);
        end
        rqst_ready_i = 1'b1;
        exp_addr = STALL_EN ? 4 : 7;
        n_left   = STALL_EN ? 12 : 9;
        for (int k = 0; k < n_left; k++) begin
            chk("s6.addr",  32'(rqst_addr_o), 32'(exp_addr));
            chk("s6.done",  32'(done_o), 0);
            chk("s6.valid", 32'(rqst_valid_o), 1);
            exp_addr++;
            tick();
        end
        chk("s6.done_pulse", 32'(done_o), 1);
        chk("s6.valid_end",  32'(rqst_valid_o), 0);
        tick();
        chk("s6.done_clear", 32'(done_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/memshare_multi_rqst_addr_gen.md
MEMSHARE_MULTI_RQST_ADDR_GEN -- requirements
Module: memshare_multi_rqst_addr_gen

Interface
REQ-001 Parameter DRC_NUM, 4, number of DRC channels, each with its own increment operand.
REQ-002 Parameter RD_ADDR_W, 4, width of the increment operand.
REQ-003 Parameter BUFF_ADDR_W, 6, width of the message-passing buffer address.
REQ-004 Parameter BUFF_DEPTH, 64, buffer depth and address wrap modulus; SHALL be at most 2**BUFF_ADDR_W.
REQ-005 Parameter TRACK_DEPTH, 2, operand tracking latency in cycles; SHALL be at least 1.
REQ-006 Parameter SHARE_LEN, 16, accepted requests per SCU.memShare() period; SHALL be at least 1.
REQ-007 sys_clk  in  1  sole clock; all logic on its rising edge.
REQ-008 rstn  in  1  reset; synchronous, active-low.
REQ-009 scu_begin_i  in  1  one-cycle pulse marking the start of SCU.memShare().
REQ-010 base_addr_i  in  BUFF_ADDR_W  start address, sampled on scu_begin_i.
REQ-011 operand_i  in  DRC_NUM*RD_ADDR_W  per-channel raw increment operand; channel k occupies bits [k*RD_ADDR_W +: RD_ADDR_W].
REQ-012 is_drc_i  in  DRC_NUM  per-channel DRC hit flags.
REQ-013 rqst_ready_i  in  1  downstream accepts the request.
REQ-014 rqst_valid_o  out  1  request address valid.
REQ-015 rqst_addr_o  out  BUFF_ADDR_W  buffer read address.
REQ-016 increment_operand_o  out  RD_ADDR_W  currently applied increment.
REQ-017 drc_base_addr_o  out  BUFF_ADDR_W  rebased address captured at the first DRC hit of the period.
REQ-018 busy_o  out  1  high in RUN.
REQ-019 done_o  out  1  one-cycle completion pulse.

Function
REQ-020 The FSM SHALL have exactly three states, IDLE, RUN and DONE, and SHALL reset to IDLE.
REQ-021 When scu_begin_i is high in any state, the block SHALL enter RUN on the next cycle, load rqst_addr_o with base_addr_i, clear the request counter and clear the DRC-captured flag.
REQ-022 operand_i SHALL be delayed by exactly TRACK_DEPTH cycles; is_drc_i SHALL NOT be delayed.
REQ-023 Each cycle, increment_operand_o SHALL register the delayed operand of the lowest-index asserted is_drc_i bit, or the value 1 when no bit is asserted, giving one further cycle of latency.
REQ-024 In RUN, rqst_valid_o SHALL be high; a request is accepted when rqst_valid_o and rqst_ready_i are both high.
REQ-025 On acceptance, rqst_addr_o SHALL advance by increment_operand_o modulo BUFF_DEPTH, with BUFF_DEPTH subtracted when the sum is at least BUFF_DEPTH, and the counter SHALL increment.
REQ-026 When rqst_ready_i is low, rqst_addr_o and the counter SHALL hold.
REQ-027 On the first cycle of a period in which any is_drc_i bit is high in RUN, drc_base_addr_o SHALL capture the current rqst_addr_o; it SHALL hold until the next scu_begin_i.
REQ-028 The acceptance that makes the count equal SHARE_LEN SHALL move the FSM to DONE; in DONE, done_o SHALL be high for one cycle and the FSM SHALL return to IDLE.
REQ-029 If scu_begin_i coincides with the final acceptance, the restart SHALL win: the FSM goes to RUN and done_o stays low.
REQ-030 A zero operand SHALL be legal and SHALL hold the address.

Reset
REQ-031 While rstn is low: FSM in IDLE, rqst_valid_o=0, rqst_addr_o=0, increment_operand_o=1, drc_base_addr_o=0, busy_o=0, done_o=0, tracking pipeline cleared to 0.
REQ-032 A reset asserted in the middle of RUN SHALL abort the period with no done_o pulse.

Configuration
REQ-033 With MEMSHARE_RQST_STALL_EN defined, rqst_ready_i SHALL apply backpressure as specified above.
REQ-034 Without MEMSHARE_RQST_STALL_EN, rqst_ready_i SHALL be ignored and treated as a constant 1, so one request is accepted every RUN cycle.

Structure
REQ-035 The state enum typedef and the default width and depth constants SHALL reside in memShare_config_pkg.
REQ-036 The operand delay SHALL use one pipeReg_insert instance of width DRC_NUM*RD_ADDR_W and depth TRACK_DEPTH.

Verification
REQ-037 Scenario: base=5, no DRC, ready constantly high -> addresses 5,6,...,20 over 16 cycles, then done_o pulses once.
REQ-038 Scenario: base=62, operand 3 on channel 1 with is_drc_i[1] held high -> addresses step by 3 and wrap 62->1->4.
REQ-039 Scenario: is_drc_i=4'b0110 with ch1 operand=2 and ch2 operand=5 -> increment_operand_o=2, matching the ch1 operand from TRACK_DEPTH+1 cycles earlier.
REQ-040 Scenario: ready low for 3 cycles mid-period (with MEMSHARE_RQST_STALL_EN defined) -> address and counter hold for those cycles and the period extends by 3 cycles.
REQ-041 Scenario: scu_begin_i on the final acceptance -> no done_o, address reloaded from base_addr_i; rstn low mid-RUN -> all outputs return to their reset values.
